// File: rtl/tis_prog_loader.sv
// tis_prog_loader
//   Loads a framed program image from a valid/ready byte stream into the
//   TIS core's instruction store. While a load is in progress the core is
//   held in reset. It is released only after the checksum of the image has
//   been verified.
//
//   Frame: L, then L words sent high byte first, then checksum C.
//   C must equal L XOR every data byte.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous, active-high reset
//   in_valid  in   byte source has a byte on in_byte
//   in_byte   in   stream byte
//   in_ready  out  loader accepts in_byte this cycle
//   prog      out  instruction store [0:DEPTH-1] x IW, wired to core.prog
//   pLength   out  verified program length (0 when no verified image)
//   core_rst  out  reset to the core; low only while a verified image is held
//   done      out  verified image held
//   err       out  last frame was rejected
module tis_prog_loader #(
  parameter int DEPTH = 15,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic [IW-1:0] prog [0:DEPTH-1],
  output logic [3:0]    pLength,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  len;
  logic [3:0]  idx;
  logic [7:0]  sum;
  logic [7:0]  hi_byte;
  logic        accept;
  logic        len_ok;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign len_ok    = (in_byte != 8'd0) && (in_byte <= 8'(DEPTH));
  assign last_word = (idx == len - 4'd1);

  // Next-state decode. Registered outputs are decoded from state_nx, so
  // they change on the same edge as the state itself.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    if (accept) begin
      unique case (state)
        IDLE, DONE, ERR: state_nx = len_ok ? HI : ERR;
        HI:              state_nx = LO;
        LO:              state_nx = last_word ? CSUM : HI;
        CSUM:            state_nx = (in_byte == sum) ? DONE : ERR;
        default:         state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= 4'd0;
      idx      <= 4'd0;
      sum      <= 8'd0;
      hi_byte  <= 8'd0;
      in_ready <= 1'b0;
      pLength  <= 4'd0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      // NOTE: the instruction store is reset explicitly. An aborted load
      // must not leave a partial image visible to the core.
      for (int i = 0; i < DEPTH; i++) prog[i] <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= 1'b1;
      done     <= (state_nx == DONE);
      err      <= (state_nx == ERR);
      core_rst <= (state_nx != DONE);
      pLength  <= (state_nx == DONE) ? len : 4'd0;

      if (accept) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            // A bad length byte goes to ERR and leaves the store untouched.
            if (len_ok) begin
              len <= in_byte[3:0];
              idx <= 4'd0;
              sum <= in_byte;
              for (int i = 0; i < DEPTH; i++) prog[i] <= '0;
            end
          end
          HI: begin
            hi_byte <= in_byte;
            sum     <= sum ^ in_byte;
          end
          LO: begin
            prog[idx] <= {hi_byte, in_byte};
            sum       <= sum ^ in_byte;
            if (!last_word) idx <= idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/tis_prog_loader.md
# tis_prog_loader

Byte-stream program writer for the TIS core: accepts a framed program image (length, 16-bit instruction words, checksum) over a valid/ready byte interface, fills the 15-entry × 16-bit instruction store, and presents it to the core on the core's `prog`/`pLength` inputs. While a load is in progress the loader holds the core in reset, and it releases the core only after a checksum-verified image is in place. It sits between the host/UART byte source and `core`, replacing the `$readmemh` preload used in simulation.

## Interface
Parameters:
- `DEPTH`, 15, instruction store entries; `pLength` must be ≤ `DEPTH`.
- `IW`, 16, instruction word width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  byte source has a byte on `in_byte`.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts `in_byte` this cycle.
- `prog`  out  `DEPTH`×`IW` (unpacked `[0:DEPTH-1]`)  instruction store, wired to `core.prog`.
- `pLength`  out  4  valid program length, wired to `core.pLength`; 0 when no valid image is held.
- `core_rst`  out  1  reset to `core`; high except while a verified image is held.
- `done`  out  1  verified image held.
- `err`  out  1  last frame was rejected.

## Operation
- Frame format: `L`, then `L` words sent high byte first (`H0 L0 H1 L1 …`), then checksum `C`. `C` must equal the XOR of `L` and every data byte.
- A byte is accepted on any edge where `in_valid && in_ready`. After reset, `in_ready` is 1 in every state. The source may stall indefinitely between bytes.
- FSM states: `IDLE`, `HI`, `LO`, `CSUM`, `DONE`, `ERR`. Reset enters `IDLE`.
- `IDLE`, `DONE`, `ERR` on accept of byte `b`:
  - If `1 ≤ b ≤ DEPTH`:
    - Latch `len=b` and set `idx=0`, `sum=b`.
    - Clear all `prog` entries to 0.
    - Go to `HI`.
  - Otherwise (`b=0` or `b>DEPTH`): go to `ERR` and leave `prog` unchanged.
- `HI` on accept: latch the high byte, set `sum^=b`, go to `LO`.
- `LO` on accept:
  - Write `prog[idx]={hi,b}` and set `sum^=b`.
  - If `idx==len-1`, go to `CSUM`; else `idx++` and go to `HI`.
- `CSUM` on accept: if `b==sum` go to `DONE`, else go to `ERR`.
- Outputs are registered and decoded from the next state:
  - `done = (state==DONE)`.
  - `err = (state==ERR)`.
  - `core_rst = !(state==DONE)`.
  - `pLength = (state==DONE) ? len : 0`.
- Entering `IDLE`, `HI`, `LO`, `CSUM` or `ERR` from `DONE` raises `core_rst` in the same edge. Any new frame therefore halts the running core.
- A rejected frame leaves `prog` partially written or cleared. This is harmless because `pLength=0` and `core_rst=1` until a later frame verifies.
- `in_valid` low: the FSM holds state and no register changes.

## Timing
- Reset values, taking effect on the first edge with `rst=1` and held while `rst` is asserted:
  - `in_ready=0`, `prog` all 0, `pLength=0`.
  - `core_rst=1`, `done=0`, `err=0`.
  - Internal state: `state=IDLE`, `idx=0`, `sum=0`.
- `rst` asserted mid-frame aborts the frame. The partial image is discarded (cleared to 0).
- `prog[idx]` is visible on the edge that accepts the low byte.
- Latency from accepting `C` to the output change is one edge: `done=1`, `core_rst=0`, `pLength=len` after that edge. The core's first fetch follows on the next edge.
- `err` and `done` are never both high. `err` clears on acceptance of the next byte with a valid length.
- Minimum frame is 2·L+2 bytes. At one byte per cycle, a 15-word load takes 32 cycles.

## Test plan
- Reset then frame `04 | 00 11 22 33 44 55 66 77 | C=04^00^11^22^33^44^55^66^77=04` -> after the edge accepting `C`: `prog[0..3]=0011,2233,4455,6677`, `prog[4..14]=0`, `pLength=4`, `done=1`, `core_rst=0`, `err=0`. `core_rst` stays 1 on every earlier cycle.
- Same frame with `C=05` -> `err=1`, `done=0`, `pLength=0`, `core_rst=1`. Then resend the correct frame -> `done=1`.
- Length bytes `00` and `10` (hex) -> `ERR` after one byte. `prog` is unchanged from the previous load and `pLength=0`.
- 15-word frame (`0F`, words `i*0x0101` for `i=0..14`, correct `C`) with `in_valid` toggling 1/0 every cycle -> all 15 entries correct, `pLength=15`, and no state change on `in_valid=0` cycles.
- Load a 4-word image, then send byte `02` -> `core_rst=1`, `pLength=0`, `prog` all zero on the edge that accepts `02`. Completing the 2-word frame gives `pLength=2`.
- `rst` pulsed after `H1` of the first frame -> all outputs return to their reset values. A fresh full frame then loads correctly.
